avalon_burst_slave_interface: RTL and testbench
===============================================

Name: avalon_burst_slave_interface

Overview:
Avalon-MM burst-capable slave that bridges an Avalon master onto the internal user bus (AW/W/B/AR/R channels).
- Supports bursts of 1..256 beats on both the read and write paths.
- Provides byte strobes and waits for the write response before accepting the next command.
- Bounds in-flight read beats with a credit counter.
- Sits between the Avalon interconnect and the DMAC/IO-channel user logic.

Parameters:
C_AVS_ADDR_WIDTH, 32, address width on both buses
C_AVS_DATA_WIDTH, 32, data width; multiple of 8
C_AVS_BURST_WIDTH, 9, avs_burstcount width; legal range 1..9
C_MAX_RD_BEATS, 256, maximum outstanding read beats; must be >= 2^(C_AVS_BURST_WIDTH-1)

Ports:
ACLK  in  1  clock
ARESETN  in  1  reset, asynchronous, active-low
avs_address  in  C_AVS_ADDR_WIDTH  burst start address
avs_burstcount  in  C_AVS_BURST_WIDTH  beats in burst; 0 treated as 1
avs_byteenable  in  C_AVS_DATA_WIDTH/8  per-beat byte enables
avs_waitrequest  out  1  stall
avs_read  in  1  read command
avs_readdata  out  C_AVS_DATA_WIDTH  read data
avs_readdatavalid  out  1  read data valid
avs_write  in  1  write beat
avs_writedata  in  C_AVS_DATA_WIDTH  write data
awvalid/awready  out/in  1  write address handshake
awaddr  out  C_AVS_ADDR_WIDTH  latched burst address
awlen  out  8  burst beats minus 1
wvalid/wready  out/in  1  write data handshake
wdata  out  C_AVS_DATA_WIDTH  write data
wstrb  out  C_AVS_DATA_WIDTH/8  byte strobes
wlast  out  1  final beat of burst
bvalid/bready  in/out  1  write response handshake
arvalid/arready  out/in  1  read address handshake
araddr  out  C_AVS_ADDR_WIDTH  latched read address
arlen  out  8  read beats minus 1
rvalid/rready  in/out  1  read data handshake
rdata  in  C_AVS_DATA_WIDTH  read data

Behaviour:
Reset:
- ARESETN low asynchronously forces state IDLE.
- Beat counter and outstanding-read counter are cleared to 0; latched addr/len are cleared to 0.
- Outputs during and after reset: awvalid=wvalid=arvalid=bready=0, avs_waitrequest=1.
- Reset mid-burst aborts the burst with no completion; the user side is reset concurrently.

FSM states: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR.
- IDLE: avs_waitrequest=1.
  - avs_write: latch address and len=max(burstcount,1)-1 -> WR_ADDR. Write takes priority if avs_write and avs_read are both high.
  - Else avs_read and outstanding + len + 1 <= C_MAX_RD_BEATS: latch -> RD_ADDR.
  - Read that fails the credit check: stay in IDLE; the master is stalled.
- WR_ADDR: awvalid=1 with latched awaddr/awlen; avs_waitrequest=1. awready -> WR_DATA with beat counter=0. No data is consumed in this state.
- WR_DATA:
  - wvalid=avs_write; wdata/wstrb driven combinationally from avs_writedata/avs_byteenable.
  - wlast = (beat==len).
  - avs_waitrequest = !wready.
  - A beat transfers when avs_write && wready: beat increments.
  - Transfer of the last beat -> WR_RESP.
  - avs_write low between beats is legal; the FSM waits in WR_DATA.
- WR_RESP: bready=1, avs_waitrequest=1; bvalid -> IDLE.
- RD_ADDR: arvalid=1, avs_waitrequest = !arready.
  - arready: the command is accepted that cycle (waitrequest low), outstanding += len+1, -> IDLE.

Read return path:
- rready=1 always; avs_readdata=rdata, avs_readdatavalid=rvalid (combinational, zero latency).
- Each rvalid decrements outstanding.
- Increment and decrement in the same cycle: outstanding += len+1-1.
- Counter width clog2(C_MAX_RD_BEATS+1); it never wraps because the credit check guarantees this.

Throughput: minimum command overhead is 1 cycle in IDLE plus 1 cycle in the address state.

Test Plan:
- Single write: addr 0x100, burstcount 1, data 0xDEADBEEF, byteenable 0xF -> awaddr 0x100 awlen 0; one W beat with wlast=1, wstrb 0xF; waitrequest released only on that beat; returns to IDLE after bvalid.
- 4-beat write burst, wready toggled every other cycle and avs_write gapped once -> exactly 4 W transfers, wlast only on the 4th, data order preserved.
- Read burst of 8 at 0x2000 -> arlen 7; 8 rdata beats passed through with readdatavalid; outstanding returns to 0.
- C_MAX_RD_BEATS=8: issue read burst 8, then read burst 1 before any rvalid -> second read stalled (waitrequest=1, arvalid=0) until first rvalid, then accepted.
- burstcount 0 -> treated as 1, awlen/arlen 0; burstcount 256 -> len 255, wlast on beat 256.
- Assert ARESETN low during WR_DATA beat 2 of 4 -> immediate IDLE, awvalid/wvalid/bready 0, waitrequest 1; a fresh write after release completes normally.

Source files
------------

// File: rtl/avalon_burst_slave_interface.sv
// Avalon-MM burst slave bridging onto the internal AW/W/B/AR/R user bus.
// Writes wait for their response before the next command; reads are bounded by a beat credit.
module avalon_burst_slave_interface #(
    parameter int C_AVS_ADDR_WIDTH  = 32,
    parameter int C_AVS_DATA_WIDTH  = 32,
    parameter int C_AVS_BURST_WIDTH = 9,
    parameter int C_MAX_RD_BEATS    = 256
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [C_AVS_ADDR_WIDTH-1:0]   avs_address,
    input  logic [C_AVS_BURST_WIDTH-1:0]  avs_burstcount,
    input  logic [C_AVS_DATA_WIDTH/8-1:0] avs_byteenable,
    output logic                          avs_waitrequest,
    input  logic                          avs_read,
    output logic [C_AVS_DATA_WIDTH-1:0]   avs_readdata,
    output logic                          avs_readdatavalid,
    input  logic                          avs_write,
    input  logic [C_AVS_DATA_WIDTH-1:0]   avs_writedata,
    output logic                          awvalid,
    input  logic                          awready,
    output logic [C_AVS_ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]                    awlen,
    output logic                          wvalid,
    input  logic                          wready,
    output logic [C_AVS_DATA_WIDTH-1:0]   wdata,
    output logic [C_AVS_DATA_WIDTH/8-1:0] wstrb,
    output logic                          wlast,
    input  logic                          bvalid,
    output logic                          bready,
    output logic                          arvalid,
    input  logic                          arready,
    output logic [C_AVS_ADDR_WIDTH-1:0]   araddr,
    output logic [7:0]                    arlen,
    input  logic                          rvalid,
    output logic                          rready,
    input  logic [C_AVS_DATA_WIDTH-1:0]   rdata
);

    localparam int CNT_W = $clog2(C_MAX_RD_BEATS + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        WR_RESP = 3'd3,
        RD_ADDR = 3'd4
    } state_t;

    state_t                      state_r;
    state_t                      state_s;
    logic [C_AVS_ADDR_WIDTH-1:0] addr_r;
    logic [7:0]                  len_r;
    logic [7:0]                  beat_r;
    logic [CNT_W-1:0]            outstanding_r;
    logic [CNT_W-1:0]            rd_inc_s;
    logic [CNT_W-1:0]            rd_dec_s;
    logic [7:0]                  cmd_len_s;
    logic                        credit_ok_s;
    logic                        latch_s;
    logic                        beat_done_s;
    logic                        rd_accept_s;

    // A burstcount of zero is treated as a single beat.
    function automatic logic [7:0] burst_len(input logic [C_AVS_BURST_WIDTH-1:0] bc);
        logic [8:0] beats;
        beats = 9'(bc);
        if (beats == 9'd0) begin
            beats = 9'd1;
        end else begin
            beats = beats;
        end
        return 8'(beats - 9'd1);
    endfunction

    assign cmd_len_s   = burst_len(avs_burstcount);
    assign credit_ok_s = (32'(outstanding_r) + 32'(cmd_len_s) + 32'd1) <= 32'(C_MAX_RD_BEATS);

    assign awaddr            = addr_r;
    assign araddr            = addr_r;
    assign awlen             = len_r;
    assign arlen             = len_r;
    assign wdata             = avs_writedata;
    assign wstrb             = avs_byteenable;
    assign rready            = 1'b1;
    assign avs_readdata      = rdata;
    assign avs_readdatavalid = rvalid;

    // Next-state and handshake outputs.
    always_comb begin
        state_s         = state_r;
        avs_waitrequest = 1'b1;
        awvalid         = 1'b0;
        wvalid          = 1'b0;
        wlast           = 1'b0;
        bready          = 1'b0;
        arvalid         = 1'b0;
        latch_s         = 1'b0;
        beat_done_s     = 1'b0;
        rd_accept_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (avs_write) begin
                    latch_s = 1'b1;
                    state_s = WR_ADDR;
                end else if (avs_read && credit_ok_s) begin
                    latch_s = 1'b1;
                    state_s = RD_ADDR;
                end else begin
                    state_s = IDLE;
                end
            end
            WR_ADDR: begin
                awvalid = 1'b1;
                if (awready) begin
                    state_s = WR_DATA;
                end else begin
                    state_s = WR_ADDR;
                end
            end
            WR_DATA: begin
                wvalid          = avs_write;
                wlast           = (beat_r == len_r);
                avs_waitrequest = !wready;
                if (avs_write && wready) begin
                    beat_done_s = 1'b1;
                    if (beat_r == len_r) begin
                        state_s = WR_RESP;
                    end else begin
                        state_s = WR_DATA;
                    end
                end else begin
                    state_s = WR_DATA;
                end
            end
            WR_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    state_s = IDLE;
                end else begin
                    state_s = WR_RESP;
                end
            end
            RD_ADDR: begin
                arvalid         = 1'b1;
                avs_waitrequest = !arready;
                if (arready) begin
                    rd_accept_s = 1'b1;
                    state_s     = IDLE;
                end else begin
                    state_s = RD_ADDR;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Command address/length latched when a command leaves IDLE.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            addr_r <= {C_AVS_ADDR_WIDTH{1'b0}};
            len_r  <= 8'd0;
        end else if (latch_s) begin
            addr_r <= avs_address;
            len_r  <= cmd_len_s;
        end else begin
            addr_r <= addr_r;
            len_r  <= len_r;
        end
    end

    // Write beat counter, restarted on address acceptance.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            beat_r <= 8'd0;
        end else if ((state_r == WR_ADDR) && awready) begin
            beat_r <= 8'd0;
        end else if (beat_done_s) begin
            beat_r <= beat_r + 8'd1;
        end else begin
            beat_r <= beat_r;
        end
    end

    assign rd_inc_s = rd_accept_s ? (CNT_W'(len_r) + CNT_W'(1'b1)) : {CNT_W{1'b0}};
    assign rd_dec_s = rvalid ? CNT_W'(1'b1) : {CNT_W{1'b0}};

    // Outstanding read beats: grows on command acceptance, shrinks per returned beat.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            outstanding_r <= {CNT_W{1'b0}};
        end else begin
            outstanding_r <= outstanding_r + rd_inc_s - rd_dec_s;
        end
    end

endmodule

// File: tb/tb_avalon_burst_slave_interface.sv
// Randomized bench for avalon_burst_slave_interface: the bench plays both the Avalon
// master and the user-side slave, predicting handshakes from a transaction-level model.
module tb_avalon_burst_slave_interface;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [31:0] avs_address;
    logic [8:0]  avs_burstcount;
    logic [3:0]  avs_byteenable;
    logic        avs_waitrequest;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bvalid, bready;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        rvalid, rready;
    logic [31:0] rdata;

    int n_chk  = 0;
    int n_pass = 0;
    int pending;
    bit ret_en;

    logic [31:0] data_a [0:255];
    logic [3:0]  strb_a [0:255];

    always #5 ACLK = ~ACLK;

    avalon_burst_slave_interface dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .avs_address(avs_address), .avs_burstcount(avs_burstcount),
        .avs_byteenable(avs_byteenable), .avs_waitrequest(avs_waitrequest),
        .avs_read(avs_read), .avs_readdata(avs_readdata),
        .avs_readdatavalid(avs_readdatavalid), .avs_write(avs_write),
        .avs_writedata(avs_writedata),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .rvalid(rvalid), .rready(rready), .rdata(rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Start of a cycle: user-side read returner drives its beat for this cycle.
    task automatic begin_cycle();
        @(negedge ACLK);
        rvalid = ret_en && (pending > 0) && ($urandom_range(3) != 0);
        rdata  = $urandom;
    endtask

    // Let combinational outputs settle, then check the read pass-through.
    task automatic settle();
        #1;
        chk("rdvalid_pass", 64'(avs_readdatavalid), 64'(rvalid));
        if (rvalid) begin
            chk("rdata_pass", 64'(avs_readdata), 64'(rdata));
            pending--;
        end
        chk("rready_high", 64'(rready), 64'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_wait"},  64'(avs_waitrequest), 64'd1);
        chk({tag, "_awv"},   64'(awvalid), 64'd0);
        chk({tag, "_wv"},    64'(wvalid), 64'd0);
        chk({tag, "_arv"},   64'(arvalid), 64'd0);
        chk({tag, "_bready"}, 64'(bready), 64'd0);
    endtask

    task automatic do_write(input logic [31:0] addr, input int bc, input logic [31:0] d0,
                            input bit rand_strb, input int wr_pct, input int gap_pct,
                            input bit both, input int abort_at);
        int n;
        int k;
        int cyc;
        bit done;
        n = (bc == 0) ? 1 : bc;
        for (int i = 0; i < 256; i++) begin
            data_a[i] = (i == 0) ? d0 : $urandom;
            strb_a[i] = rand_strb ? 4'($urandom_range(15)) : 4'hF;
        end
        begin_cycle();
        avs_write = 1'b1; avs_read = both; avs_address = addr; avs_burstcount = 9'(bc);
        avs_writedata = data_a[0]; avs_byteenable = strb_a[0];
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0;
        settle();
        chk("wr_idle_wait", 64'(avs_waitrequest), 64'd1);
        chk("wr_idle_awv", 64'(awvalid), 64'd0);
        done = 1'b0; cyc = 0;
        while (!done && cyc < 100) begin
            begin_cycle();
            avs_read = 1'b0;
            awready = ($urandom_range(99) < 50);
            settle();
            chk("aw_valid", 64'(awvalid), 64'd1);
            chk("aw_addr", 64'(awaddr), 64'(addr));
            chk("aw_len", 64'(awlen), 64'(n - 1));
            chk("aw_wait", 64'(avs_waitrequest), 64'd1);
            chk("aw_wv", 64'(wvalid), 64'd0);
            chk("aw_arv", 64'(arvalid), 64'd0);
            done = awready;
            cyc++;
        end
        if (!done) begin
            chk("aw_timeout", 64'd0, 64'd1);
            avs_write = 1'b0;
            return;
        end
        k = 0; cyc = 0;
        while (k < n && cyc < 4000) begin
            begin_cycle();
            awready = 1'b0;
            avs_write = !($urandom_range(99) < gap_pct);
            avs_writedata = avs_write ? data_a[k] : 32'($urandom);
            avs_byteenable = strb_a[k];
            wready = ($urandom_range(99) < wr_pct);
            settle();
            chk("w_valid", 64'(wvalid), 64'(avs_write));
            chk("w_wait", 64'(avs_waitrequest), 64'(!wready));
            chk("w_awv", 64'(awvalid), 64'd0);
            if (avs_write) begin
                chk("w_data", 64'(wdata), 64'(data_a[k]));
                chk("w_strb", 64'(wstrb), 64'(strb_a[k]));
                chk("w_last", 64'(wlast), 64'(k == n - 1));
            end
            if (avs_write && wready) k++;
            if (abort_at > 0 && k == abort_at) begin
                ARESETN = 1'b0;
                #1;
                pending = 0;
                check_idle_outputs("rst_mid");
                rvalid = 1'b0; avs_write = 1'b0; wready = 1'b0;
                repeat (2) @(negedge ACLK);
                #1;
                check_idle_outputs("rst_hold");
                @(negedge ACLK);
                ARESETN = 1'b1;
                return;
            end
            cyc++;
        end
        if (k < n) begin
            chk("w_timeout", 64'(k), 64'(n));
            avs_write = 1'b0;
            return;
        end
        done = 1'b0; cyc = 0;
        while (!done && cyc < 100) begin
            begin_cycle();
            avs_write = 1'b0; wready = 1'b0;
            bvalid = ($urandom_range(2) == 0);
            settle();
            chk("b_ready", 64'(bready), 64'd1);
            chk("b_wait", 64'(avs_waitrequest), 64'd1);
            chk("b_wv", 64'(wvalid), 64'd0);
            done = bvalid;
            cyc++;
        end
        if (!done) chk("b_timeout", 64'd0, 64'd1);
        begin_cycle();
        bvalid = 1'b0;
        settle();
        check_idle_outputs("wr_end");
    endtask

    task automatic do_read(input logic [31:0] addr, input int bc, input int ar_pct,
                           input int release_at);
        int n;
        int cyc;
        bit ok;
        bit acc;
        n = (bc == 0) ? 1 : bc;
        ok = 1'b0; cyc = 0;
        while (!ok && cyc < 600) begin
            if (cyc == release_at) ret_en = 1'b1;
            begin_cycle();
            avs_read = 1'b1; avs_write = 1'b0; avs_address = addr;
            avs_burstcount = 9'(bc); arready = 1'b0;
            ok = (pending + n <= 256);
            settle();
            chk("rd_idle_wait", 64'(avs_waitrequest), 64'd1);
            chk("rd_idle_arv", 64'(arvalid), 64'd0);
            cyc++;
        end
        if (!ok) begin
            chk("rd_credit_timeout", 64'd0, 64'd1);
            avs_read = 1'b0;
            return;
        end
        acc = 1'b0; cyc = 0;
        while (!acc && cyc < 100) begin
            begin_cycle();
            arready = ($urandom_range(99) < ar_pct);
            settle();
            chk("ar_valid", 64'(arvalid), 64'd1);
            chk("ar_addr", 64'(araddr), 64'(addr));
            chk("ar_len", 64'(arlen), 64'(n - 1));
            chk("ar_wait", 64'(avs_waitrequest), 64'(!arready));
            chk("ar_awv", 64'(awvalid), 64'd0);
            if (arready) begin
                acc = 1'b1;
                pending += n;
            end
            cyc++;
        end
        if (!acc) chk("ar_timeout", 64'd0, 64'd1);
        begin_cycle();
        avs_read = 1'b0; arready = 1'b0;
        settle();
        check_idle_outputs("rd_end");
    endtask

    task automatic drain();
        int cyc;
        ret_en = 1'b1;
        cyc = 0;
        while (pending > 0 && cyc < 3000) begin
            begin_cycle();
            avs_read = 1'b0; avs_write = 1'b0;
            settle();
            cyc++;
        end
        if (pending > 0) chk("drain_timeout", 64'(pending), 64'd0);
    endtask

    initial begin
        ARESETN = 1'b0;
        avs_address = 32'd0; avs_burstcount = 9'd0; avs_byteenable = 4'd0;
        avs_read = 1'b0; avs_write = 1'b0; avs_writedata = 32'd0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0;
        rvalid = 1'b0; rdata = 32'd0;
        pending = 0; ret_en = 1'b0;
        #23;
        check_idle_outputs("reset");
        @(negedge ACLK);
        ARESETN = 1'b1;
        ret_en = 1'b1;

        do_write(32'h0000_0100, 1, 32'hDEAD_BEEF, 1'b0, 100, 0, 1'b0, 0);
        do_write(32'h0000_0200, 4, 32'h1111_2222, 1'b1, 50, 30, 1'b0, 0);
        do_read(32'h0000_2000, 8, 70, -1);
        drain();
        do_write(32'h0000_0300, 0, 32'hCAFE_F00D, 1'b1, 80, 10, 1'b0, 0);
        do_read(32'h0000_0400, 0, 80, -1);
        drain();
        do_write(32'h0000_8000, 256, 32'h0BAD_CAFE, 1'b1, 80, 10, 1'b0, 0);
        do_write(32'h0000_0500, 3, 32'h5555_AAAA, 1'b1, 60, 20, 1'b1, 0);

        // Credit exhaustion: full-credit burst, then a 1-beat read held off until a return.
        ret_en = 1'b0;
        do_read(32'h0000_4000, 256, 100, -1);
        do_read(32'h0000_5000, 1, 100, 6);
        drain();
        do_read(32'h0000_6000, 256, 60, -1);
        drain();

        do_write(32'h0000_0600, 4, 32'h7777_8888, 1'b1, 100, 0, 1'b0, 2);
        do_write(32'h0000_0700, 4, 32'h9999_0000, 1'b1, 70, 20, 1'b0, 0);

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(1) == 0) begin
                do_write($urandom, $urandom_range(16), $urandom, 1'b1,
                         $urandom_range(100, 30), $urandom_range(40),
                         ($urandom_range(3) == 0), 0);
            end else begin
                do_read($urandom, $urandom_range(16), $urandom_range(100, 30), -1);
            end
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
